// File: rtl/systolic_result_writer.sv
// Purpose : de-skews the diagonally skewed result lanes of one systolic tile edge
//           into full row words and writes MATRIX_SIZE consecutive rows to a result BRAM port.
// Latency : row r is written at E0+M+1+r (E0 = accepting start edge); done pulses at E0+2M+1.
// Backpressure: none; the BRAM port always accepts, and start is ignored while busy (no queueing).
//
// Ports:
//   clk        tile clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle job pulse, accepted only in IDLE
//   base_addr  first row address, latched on the accepting edge
//   res_in     skewed result lanes, res_in[i] = column i
//   busy       job in progress (FILL/WRITE/DONE, and the cycle after DONE)
//   done       one-cycle pulse after the last row write
//   ena/wea    BRAM enable / write strobe (always equal)
//   addra      BRAM row address, wraps mod 2^BRAM_DEPTH
//   dina       row word, lane 0 in the low DATA_WIDTH bits
module systolic_result_writer #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int BRAM_DEPTH  = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [BRAM_DEPTH-1:0]                  base_addr,
  input  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] res_in,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   ena,
  output logic                                   wea,
  output logic [BRAM_DEPTH-1:0]                  addra,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0]      dina
);

  localparam int CW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                                 state;
  logic [CW-1:0]                          cnt;
  logic [BRAM_DEPTH-1:0]                  wr_addr;
  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] lane_out;
  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] row_q;

  // Lane i arrives i cycles later than lane 0 for the same row, so it gets
  // M-1-i delay stages; the last lane goes straight to the row register.
  // The delay lines run freely: anything sampled outside a job's capture
  // window has shifted out before the next job's rows are aligned.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    localparam int D = MATRIX_SIZE - 1 - i;
    if (D == 0) begin : g_pass
      assign lane_out[i] = res_in[i];
    end else begin : g_sr
      logic [D-1:0][DATA_WIDTH-1:0] sr;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sr <= '0;
        end else begin
          sr[0] <= res_in[i];
          for (int k = 1; k < D; k++) begin
            sr[k] <= sr[k-1];
          end
        end
      end
      assign lane_out[i] = sr[D-1];
    end
  end

  // Aligned row register: holds row r after edge E0+M+r, one cycle ahead of
  // the write that presents it on dina.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
    end else begin
      row_q <= lane_out;
    end
  end

  // Control FSM. cnt counts the M FILL cycles, then the M rows in WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ena     <= 1'b0;
      wea     <= 1'b0;
      addra   <= '0;
      dina    <= '0;
    end else begin
      done <= 1'b0;
      ena  <= 1'b0;
      wea  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            state   <= FILL;
            cnt     <= '0;
            wr_addr <= base_addr;
          end
        end
        FILL: begin
          if (cnt == LAST) begin
            state <= WRITE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: begin
          ena     <= 1'b1;
          wea     <= 1'b1;
          addra   <= wr_addr;
          dina    <= row_q;
          wr_addr <= wr_addr + BRAM_DEPTH'(1);
          if (cnt == LAST) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // busy stays high through the cycle after done; it clears on the
          // next IDLE edge unless a new start arrives exactly then.
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_writer.sv
module tb_systolic_result_writer;

  logic            clk;
  logic            reset;
  logic            start;
  logic [1:0]      base_addr;
  logic [3:0][15:0] res_in;
  logic            busy;
  logic            done;
  logic            ena;
  logic            wea;
  logic [1:0]      addra;
  logic [63:0]     dina;

  int checks   = 0;
  int failures = 0;

  logic [63:0] row1;

  systolic_result_writer #(
    .MATRIX_SIZE(4),
    .DATA_WIDTH (16),
    .BRAM_DEPTH (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .res_in   (res_in),
    .busy     (busy),
    .done     (done),
    .ena      (ena),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Element (r,i) = {tag, 4'h0, r, i}; tag 0 gives 16'h{r}{i}.
  function automatic logic [15:0] elem(input logic [3:0] tag, input int r, input int i);
    return {tag, 4'h0, 4'(r), 4'(i)};
  endfunction

  function automatic logic [63:0] exp_row(input logic [3:0] tag, input int r);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = elem(tag, r, i);
    return v;
  endfunction

  // Called just after edge E0+k: lane i gets row k-i, sampled at E0+k+1.
  task automatic drive(input logic [3:0] tag, input int k);
    for (int i = 0; i < 4; i++) begin
      if ((k - i) >= 0 && (k - i) < 4) res_in[i] = elem(tag, k - i, i);
      else res_in[i] = 16'hFFFF;
    end
  endtask

  // Raises start so the next edge is E0, then follows edges E0..E0+9.
  task automatic run_job(input logic [1:0] base, input logic [3:0] tag,
                         input bit extra_starts, output logic [63:0] r1);
    int writes;
    int dones;
    logic [1:0] ea;
    writes = 0;
    dones  = 0;
    r1     = '0;
    start     = 1'b1;
    base_addr = base;
    drive(tag, -1);
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk); #1;
      start     = extra_starts && (k == 2 || k == 8);
      base_addr = ~base;
      drive(tag, k);
      chk("busy", busy, 1'b1);
      chk("wea", wea, (k >= 5 && k <= 8));
      chk("ena", ena, (k >= 5 && k <= 8));
      chk("done", done, (k == 9));
      if (wea === 1'b1) begin
        ea = base + 2'(writes);
        chk("addra", addra, ea);
        chk("dina", dina, exp_row(tag, writes));
        if (writes == 1) r1 = dina;
        writes++;
      end
      if (done === 1'b1) dones++;
    end
    chk("write_count", writes, 4);
    chk("done_count", dones, 1);
  endtask

  task automatic idle_tick();
    start = 1'b0;
    @(posedge clk); #1;
    res_in = {4{16'hFFFF}};
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = 2'd0;
    res_in    = {4{16'hFFFF}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ena", ena, 1'b0);
    chk("rst_wea", wea, 1'b0);
    chk("rst_addra", addra, 2'd0);
    chk("rst_dina", dina, 64'd0);
    reset = 1'b1;
    repeat (3) idle_tick();
    chk("idle_busy", busy, 1'b0);

    // Basic job, base 0.
    run_job(2'd0, 4'h0, 1'b0, row1);
    chk("row1_word", row1, 64'h0013_0012_0011_0010);
    idle_tick();
    chk("j1_busy_clear", busy, 1'b0);
    chk("j1_done_clear", done, 1'b0);
    chk("j1_dina_hold", dina, 64'h0033_0032_0031_0030);
    chk("j1_addra_hold", addra, 2'd3);
    idle_tick();

    // Base 2 wraps 2,3,0,1; starts at E0+3 and E0+9 must be ignored.
    run_job(2'd2, 4'h0, 1'b1, row1);
    idle_tick();
    chk("j2_busy_clear", busy, 1'b0);
    chk("j2_wea_low", wea, 1'b0);
    chk("j2_addra_hold", addra, 2'd1);
    repeat (6) begin
      idle_tick();
      chk("j2_no_restart", wea, 1'b0);
    end

    // Back-to-back: second start lands at E0+10, first write at E0+15.
    run_job(2'd0, 4'hA, 1'b0, row1);
    run_job(2'd3, 4'hB, 1'b0, row1);
    chk("b2b_row1", row1, 64'hB013_B012_B011_B010);
    idle_tick();
    chk("b2b_busy_clear", busy, 1'b0);
    idle_tick();

    // Reset asserted during WRITE, right after edge E0+6.
    start     = 1'b1;
    base_addr = 2'd1;
    drive(4'hC, -1);
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive(4'hC, k);
    end
    chk("pre_abort_wea", wea, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_wea", wea, 1'b0);
    chk("abort_ena", ena, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_dina", dina, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      res_in = {4{16'h5A5A}};
      chk("post_abort_wea", wea, 1'b0);
      chk("post_abort_busy", busy, 1'b0);
    end
    idle_tick();

    // Recovery after abort.
    run_job(2'd1, 4'hD, 1'b0, row1);
    chk("rec_row1", row1, 64'hD013_D012_D011_D010);
    idle_tick();
    chk("rec_busy_clear", busy, 1'b0);
    chk("rec_addra_hold", addra, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
